// File: rtl/pos_cache_stream_pkg.sv
// pos_cache_stream_pkg: shared types and default sizes for the double-buffered position cache.
// rev 1.0
`default_nettype none

package pos_cache_stream_pkg;

  localparam int POS_CACHE_DEPTH = 128;
  localparam int POS_CACHE_ID_W  = $clog2(POS_CACHE_DEPTH);
  localparam int OFFSET_POS_W    = 27;
  localparam int ELEMENT_W       = 2;
  localparam int LIFETIME_W      = 4;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_MU     = 3'd4,
    ST_FINISH = 3'd5
  } pos_cache_state_t;

  typedef struct packed {
    logic [POS_CACHE_ID_W-1:0] id;
    logic [ELEMENT_W-1:0]      element;
    logic [OFFSET_POS_W-1:0]   pos;
  } offset_pkt_t;

endpackage

`default_nettype wire

// File: rtl/pos_cache_bank_ram.sv
// pos_cache_bank_ram: simple dual-port bank RAM, one write port, registered read (1-cycle latency).
// rev 1.0
`default_nettype none

module pos_cache_bank_ram #(
  parameter  int DEPTH  = 128,
  parameter  int DATA_W = 29,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

`default_nettype wire

// File: rtl/pos_cache_stream.sv
// pos_cache_stream: double-buffered home-cell position cache streaming the active bank to the PE ring.
// rev 1.0
`default_nettype none

module pos_cache_stream
  import pos_cache_stream_pkg::*;
#(
  parameter  int                          DEPTH          = POS_CACHE_DEPTH,
  parameter  int                          POS_W          = OFFSET_POS_W,
  parameter  int                          ELEM_W         = ELEMENT_W,
  parameter  int                          GCID_W         = 2,
  parameter  int                          NUM_DEST       = 4,
  parameter  int                          LIFE_W         = LIFETIME_W,
  parameter  logic [3*GCID_W-1:0]         HOME_GCID      = '0,
  parameter  logic [(NUM_DEST+1)*LIFE_W-1:0] SPLIT_LIFETIME = '0,
  localparam int                          ID_W           = $clog2(DEPTH),
  localparam int                          DATA_W         = ELEM_W + POS_W,
  localparam int                          PKT_W          = ID_W + DATA_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_init_wr_en,
  input  logic [ID_W-1:0]                i_init_wr_addr,
  input  logic [POS_W-1:0]               i_init_data,
  input  logic [ELEM_W-1:0]              i_init_element,
  input  logic                           i_init_done,
  input  logic                           i_PE_start,
  input  logic                           i_ready,
  output logic [PKT_W-1:0]               o_pos_pkt,
  output logic                           o_valid,
  output logic                           o_stream_done,
  output logic [3*GCID_W-1:0]            o_cur_gcid,
  output logic [(NUM_DEST+1)*LIFE_W-1:0] o_split_lifetime,
  input  logic                           i_MU_start,
  input  logic                           i_MU_rd_en,
  input  logic [ID_W-1:0]                i_MU_rd_addr,
  output logic [DATA_W-1:0]              o_MU_rd_data,
  output logic                           o_MU_rd_valid,
  input  logic                           i_MU_wr_en,
  input  logic [POS_W-1:0]               i_MU_wr_pos,
  input  logic [ELEM_W-1:0]              i_MU_wr_element,
  input  logic                           i_MU_done,
  input  logic                           i_iter_target_reached,
  output logic [ID_W:0]                  o_num_particles,
  output logic                           o_overflow,
  output logic [2:0]                     o_state
);

  localparam logic [ID_W:0] CNT_ONE   = {{ID_W{1'b0}}, 1'b1};
  localparam logic [ID_W:0] CNT_DEPTH = (ID_W+1)'(DEPTH);

  pos_cache_state_t  state_q, state_d;
  logic              bank_sel_q, bank_sel_d;
  logic              rd_bank_q, rd_bank_d;
  logic [ID_W:0]     count_q, count_d;
  logic [ID_W:0]     wr_ptr_q, wr_ptr_d;
  logic [ID_W:0]     rd_ptr_q, rd_ptr_d;
  logic              pend_q, pend_d;
  logic [ID_W-1:0]   pend_id_q, pend_id_d;
  logic [1:0]        skid_cnt_q, skid_cnt_d;
  logic [PKT_W-1:0]  skid0_q, skid0_d;
  logic [PKT_W-1:0]  skid1_q, skid1_d;
  logic              done_q, done_d;
  logic              overflow_q, overflow_d;
  logic              mu_rd_valid_q, mu_rd_valid_d;

  logic              issue;
  logic [ID_W-1:0]   issue_addr;
  logic              pop;
  logic [2:0]        occ;
  logic              room;
  logic              init_we;
  logic              mu_we;
  logic [ID_W:0]     wr_ptr_next;
  logic [PKT_W-1:0]  push_pkt;

  logic [1:0]        bank_we;
  logic [ID_W-1:0]   bank_waddr;
  logic [DATA_W-1:0] bank_wdata;
  logic [ID_W-1:0]   bank_raddr;
  logic [DATA_W-1:0] bank_rdata [2];
  logic [DATA_W-1:0] act_rdata;

  always_comb begin
    state_d       = state_q;
    bank_sel_d    = bank_sel_q;
    rd_bank_d     = bank_sel_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    pend_d        = 1'b0;
    pend_id_d     = pend_id_q;
    done_d        = 1'b0;
    overflow_d    = overflow_q;
    mu_rd_valid_d = 1'b0;
    issue         = 1'b0;
    issue_addr    = rd_ptr_q[ID_W-1:0];
    init_we       = 1'b0;
    mu_we         = 1'b0;
    wr_ptr_next   = wr_ptr_q;
    pop           = (skid_cnt_q != 2'd0) && i_ready;
    // Slots still needed once this cycle's pop and in-flight read settle; a new read must fit too.
    occ           = 3'(skid_cnt_q) + 3'(pend_q) - 3'(pop);
    room          = (occ <= 3'd1);

    case (state_q)
      ST_INIT: begin
        if (i_init_wr_en) begin
          init_we = 1'b1;
          if ({1'b0, i_init_wr_addr} >= count_q) begin
            count_d = {1'b0, i_init_wr_addr} + CNT_ONE;
          end
        end
        if (i_init_done) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (i_PE_start) begin
          if (count_q == '0) begin
            done_d = 1'b1;
          end else begin
            // Slot 0 is read in the start cycle so the first packet is valid two cycles later.
            issue      = 1'b1;
            issue_addr = '0;
            rd_ptr_d   = CNT_ONE;
            state_d    = ST_STREAM;
          end
        end else if (i_MU_start) begin
          state_d = ST_MU;
        end
      end
      ST_STREAM: begin
        if (rd_ptr_q == count_q) begin
          state_d = ST_DRAIN;
        end else if (room) begin
          issue    = 1'b1;
          rd_ptr_d = rd_ptr_q + CNT_ONE;
        end
      end
      ST_DRAIN: begin
        if (pop && (skid_cnt_q == 2'd1) && !pend_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_MU: begin
        mu_rd_valid_d = i_MU_rd_en;
        if (i_MU_wr_en) begin
          if (wr_ptr_q == CNT_DEPTH) begin
            overflow_d = 1'b1;
          end else begin
            mu_we       = 1'b1;
            wr_ptr_next = wr_ptr_q + CNT_ONE;
          end
        end
        wr_ptr_d = wr_ptr_next;
        if (i_MU_done) begin
          bank_sel_d = ~bank_sel_q;
          count_d    = wr_ptr_next;
          wr_ptr_d   = '0;
          state_d    = i_iter_target_reached ? ST_FINISH : ST_IDLE;
        end
      end
      ST_FINISH: begin
        state_d = ST_FINISH;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    if (issue) begin
      pend_d    = 1'b1;
      pend_id_d = issue_addr;
    end
  end

  assign act_rdata = rd_bank_q ? bank_rdata[1] : bank_rdata[0];
  assign push_pkt  = {pend_id_q, act_rdata};

  always_comb begin
    skid0_d    = skid0_q;
    skid1_d    = skid1_q;
    skid_cnt_d = skid_cnt_q;
    case ({pend_q, pop})
      2'b11: begin
        if (skid_cnt_q == 2'd2) begin
          skid0_d = skid1_q;
          skid1_d = push_pkt;
        end else begin
          skid0_d = push_pkt;
        end
      end
      2'b10: begin
        if (skid_cnt_q == 2'd0) begin
          skid0_d = push_pkt;
        end else begin
          skid1_d = push_pkt;
        end
        skid_cnt_d = skid_cnt_q + 2'd1;
      end
      2'b01: begin
        skid0_d    = skid1_q;
        skid_cnt_d = skid_cnt_q - 2'd1;
      end
      default: begin
        skid_cnt_d = skid_cnt_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_INIT;
      bank_sel_q    <= 1'b0;
      rd_bank_q     <= 1'b0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      pend_q        <= 1'b0;
      pend_id_q     <= '0;
      skid_cnt_q    <= 2'd0;
      skid0_q       <= '0;
      skid1_q       <= '0;
      done_q        <= 1'b0;
      overflow_q    <= 1'b0;
      mu_rd_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bank_sel_q    <= bank_sel_d;
      rd_bank_q     <= rd_bank_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      pend_q        <= pend_d;
      pend_id_q     <= pend_id_d;
      skid_cnt_q    <= skid_cnt_d;
      skid0_q       <= skid0_d;
      skid1_q       <= skid1_d;
      done_q        <= done_d;
      overflow_q    <= overflow_d;
      mu_rd_valid_q <= mu_rd_valid_d;
    end
  end

  // Init fills the active bank; MU appends into the shadow bank.
  assign bank_waddr = init_we ? i_init_wr_addr : wr_ptr_q[ID_W-1:0];
  assign bank_wdata = init_we ? {i_init_element, i_init_data} : {i_MU_wr_element, i_MU_wr_pos};
  assign bank_raddr = issue ? issue_addr : i_MU_rd_addr;

  for (genvar g = 0; g < 2; g++) begin : g_bank
    assign bank_we[g] = (init_we && (bank_sel_q == 1'(g))) ||
                        (mu_we   && (bank_sel_q != 1'(g)));

    pos_cache_bank_ram #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
    ) u_ram (
      .clk       (clk),
      .wr_en_i   (bank_we[g]),
      .wr_addr_i (bank_waddr),
      .wr_data_i (bank_wdata),
      .rd_addr_i (bank_raddr),
      .rd_data_o (bank_rdata[g])
    );
  end

  assign o_pos_pkt        = skid0_q;
  assign o_valid          = (skid_cnt_q != 2'd0);
  assign o_stream_done    = done_q;
  assign o_cur_gcid       = HOME_GCID;
  assign o_split_lifetime = SPLIT_LIFETIME;
  assign o_MU_rd_data     = mu_rd_valid_q ? act_rdata : '0;
  assign o_MU_rd_valid    = mu_rd_valid_q;
  assign o_num_particles  = count_q;
  assign o_overflow       = overflow_q;
  assign o_state          = state_q;

endmodule

`default_nettype wire

// File: doc/pos_cache_stream.md
Name: pos_cache_stream

Overview:
- Parametrised, double-buffered position cache for one home cell. Successor to the fixed 8-cell cache array.
- Streams the active bank to the PE ring with valid/ready backpressure, tagging each packet with a per-destination split lifetime.
- Serves Motion Update (MU): reads come from the active bank; writes compact into the shadow bank; banks swap on MU done.
- Sits between the init loader / MU and the PE position ring; one instance per cell, generated by the array wrapper.

Parameters:
DEPTH, 128, particle slots per bank (power of 2); ID_W = $clog2(DEPTH)
POS_W, 27, offset position struct width (3 x 9-bit fixed offsets)
ELEM_W, 2, element type width
GCID_W, 2, global cell ID width per axis
NUM_DEST, 4, remote destination nodes (lifetime fields = NUM_DEST+1)
LIFE_W, 4, width of one split-lifetime field
HOME_GCID, 0, {x,y,z} home cell ID, 3*GCID_W bits
SPLIT_LIFETIME, 0, (NUM_DEST+1)*LIFE_W lifetime vector, field 0 = all

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
i_init_wr_en  in  1  init write into active bank
i_init_wr_addr  in  ID_W  init slot address
i_init_data  in  POS_W  init position
i_init_element  in  ELEM_W  init element
i_init_done  in  1  pulse: count = highest init addr + 1; INIT -> IDLE
i_PE_start  in  1  pulse: stream active bank
i_ready  in  1  downstream accepts packet
o_pos_pkt  out  ID_W+ELEM_W+POS_W  {particle_id, element, pos}
o_valid  out  1  packet valid
o_stream_done  out  1  one-cycle pulse after last accept (or empty bank)
o_cur_gcid  out  3*GCID_W  constant HOME_GCID
o_split_lifetime  out  (NUM_DEST+1)*LIFE_W  constant SPLIT_LIFETIME
i_MU_start  in  1  pulse: enter MU phase
i_MU_rd_en  in  1  MU read from active bank
i_MU_rd_addr  in  ID_W  MU read address
o_MU_rd_data  out  ELEM_W+POS_W  read data, 1-cycle latency
o_MU_rd_valid  out  1  rd_en delayed 1 cycle
i_MU_wr_en  in  1  append to shadow bank
i_MU_wr_pos  in  POS_W  updated position
i_MU_wr_element  in  ELEM_W  element
i_MU_done  in  1  pulse: swap banks
i_iter_target_reached  in  1  level: finish after current MU
o_num_particles  out  ID_W+1  active-bank count
o_overflow  out  1  sticky: shadow append beyond DEPTH
o_state  out  3  FSM state (debug)

Behaviour:
- Reset (rst low, async):
  - FSM=INIT, bank_sel=0, counts=0, wr_ptr=0.
  - o_valid=0, o_stream_done=0, o_MU_rd_valid=0, o_overflow=0, o_pos_pkt=0, o_MU_rd_data=0, o_state=0.
  - Reset mid-stream or mid-MU discards all progress. RAM contents are not cleared.
- FSM encoding: INIT=0, IDLE=1, STREAM=2, DRAIN=3, MU=4, FINISH=5.
  - INIT: accept init writes; i_init_done -> IDLE.
  - IDLE:
    - i_PE_start -> STREAM, rd_ptr=0. If count==0: pulse o_stream_done next cycle, stay IDLE.
    - i_MU_start -> MU. If both pulses arrive together, PE_start wins and MU_start is dropped.
  - STREAM: issue reads while rd_ptr<count and the 2-entry skid buffer has room. When rd_ptr==count -> DRAIN.
  - DRAIN: when the final handshake (o_valid&&i_ready) occurs, pulse o_stream_done -> IDLE.
  - MU:
    - Each i_MU_wr_en writes shadow[wr_ptr] and increments wr_ptr.
    - If wr_ptr==DEPTH: drop the write, set o_overflow, saturate wr_ptr.
    - On i_MU_done: flip bank_sel, count=wr_ptr, wr_ptr=0. Go to FINISH if i_iter_target_reached, else IDLE.
  - FINISH: terminal until reset; PE/MU starts ignored.
- Stream handshake:
  - First o_valid 2 cycles after i_PE_start.
  - o_pos_pkt held stable while o_valid && !i_ready.
  - 1 packet/cycle while i_ready is held high.
  - Packets are emitted in ascending particle_id order, with no gaps or duplicates.
- PE_start or MU_start outside IDLE is ignored.
- MU reads and MU writes in the same cycle are legal (different banks).
- MU reads are honoured only in MU state. In other states o_MU_rd_valid stays 0.
- Init writes outside INIT are ignored.
- i_MU_done with zero writes: count becomes 0 (empty cell).

Decomposition:
- MD_pkg additions:
  - POS_CACHE_DEPTH and state enum pos_cache_state_t.
  - Packet struct offset_pkt_t {id, element, pos}.
  - Lifetime field width.
- Sub-module pos_cache_bank_ram: simple dual-port RAM, 1-cycle read, 2 instances.
- Skid buffer stays inline.

Test Plan:
- Init addrs 0..4, init_done, PE_start, i_ready=1 -> ids 0..4 on 5 consecutive cycles; first valid at cycle+2; o_stream_done once after id 4.
- Same stream with i_ready toggling 1,0,0,1 -> each packet held unchanged while stalled; no loss or duplication; 5 packets total.
- Empty cell (init_done with no writes), PE_start -> o_valid never high; o_stream_done pulse within 2 cycles; state returns to IDLE (1).
- MU: read addr 3 -> data returns next cycle with o_MU_rd_valid. Append 3 writes, MU_done -> o_num_particles=3; next stream emits the 3 new positions as ids 0..2.
- DEPTH=8, MU appends 10 -> o_overflow=1 sticky; count=8 after MU_done.
- i_iter_target_reached=1 at MU_done -> state FINISH (5); later PE_start gives no o_valid. Async rst low mid-STREAM -> o_valid=0 immediately, state INIT.
